// File: rtl/bf_bus_pkg.sv
// Shared constants for the brainfuck data-bus controller: data width and
// the controller FSM state encoding.
package bf_bus_pkg;

    localparam int BF_DATA_W = 8;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_C_MEM  = 3'd1;
    localparam logic [2:0] S_C_DONE = 3'd2;
    localparam logic [2:0] S_H_MEM  = 3'd3;
    localparam logic [2:0] S_H_DONE = 3'd4;
    localparam logic [2:0] S_IO_WR  = 3'd5;
    localparam logic [2:0] S_IO_RD  = 3'd6;

endpackage

// File: rtl/bf_out_fifo.sv
// Circular output-character FIFO. Pointers wrap naturally because DEPTH is a
// power of two; occupancy is tracked in a separate counter.
module bf_out_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [W-1:0]             wdata,
    output logic                     full,
    input  logic                     pop,
    output logic [W-1:0]             rdata,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Storage is not reset; clearing the pointers and count discards contents.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push_ok && !pop_ok) begin
                count <= count + 1'b1;
            end else if (!push_ok && pop_ok) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/bf_bus_ctrl.sv
// Data-bus controller for brainfuck_cpu: arbitrates the tape RAM between the
// CPU and a host port, and bridges CPU I/O cycles to a tx FIFO and rx channel.
module bf_bus_ctrl
    import bf_bus_pkg::*;
#(
    parameter int DATA_AW    = 11,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_AW-1:0]            cpu_addr,
    input  logic [BF_DATA_W-1:0]          cpu_wdata,
    output logic [BF_DATA_W-1:0]          cpu_rdata,
    input  logic                          cpu_rd,
    input  logic                          cpu_wr,
    input  logic                          cpu_mreq,
    input  logic                          cpu_ioreq,
    output logic                          cpu_ready,
    output logic [DATA_AW-1:0]            ram_addr,
    output logic [BF_DATA_W-1:0]          ram_wdata,
    input  logic [BF_DATA_W-1:0]          ram_rdata,
    output logic                          ram_en,
    output logic                          ram_we,
    input  logic                          host_req,
    input  logic                          host_we,
    input  logic [DATA_AW-1:0]            host_addr,
    input  logic [BF_DATA_W-1:0]          host_wdata,
    output logic [BF_DATA_W-1:0]          host_rdata,
    output logic                          host_ack,
    output logic [BF_DATA_W-1:0]          tx_data,
    output logic                          tx_valid,
    input  logic                          tx_ready,
    input  logic [BF_DATA_W-1:0]          rx_data,
    input  logic                          rx_valid,
    output logic                          rx_ack,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [2:0]                    dbg_state
);

    // Handshakes: cpu strobes and host_req are held until a one-cycle
    // cpu_ready/host_ack pulse and must drop in that pulse cycle; tx moves a
    // byte on any cycle with tx_valid & tx_ready; rx_ack pulses once to
    // consume rx_data while rx_valid is high.

    logic [2:0]           state;
    logic [DATA_AW-1:0]   addr_q;
    logic [BF_DATA_W-1:0] wdata_q;
    logic [BF_DATA_W-1:0] rx_q;
    logic                 we_q;
    logic                 mem_rd_q;
    logic                 io_rd_q;
    logic                 fifo_push;
    logic                 fifo_full;
    logic                 fifo_empty;

    assign dbg_state = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            rx_q     <= '0;
            we_q     <= 1'b0;
            mem_rd_q <= 1'b0;
            io_rd_q  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (host_req) begin
                        state    <= S_H_MEM;
                        addr_q   <= host_addr;
                        wdata_q  <= host_wdata;
                        we_q     <= host_we;
                        mem_rd_q <= 1'b0;
                        io_rd_q  <= 1'b0;
                    end else if (cpu_rd || cpu_wr) begin
                        addr_q   <= cpu_addr;
                        wdata_q  <= cpu_wdata;
                        we_q     <= cpu_wr;
                        mem_rd_q <= 1'b0;
                        io_rd_q  <= 1'b0;
                        // I/O qualifier wins; an unqualified strobe is a no-op.
                        if (cpu_ioreq) begin
                            state   <= cpu_wr ? S_IO_WR : S_IO_RD;
                            io_rd_q <= !cpu_wr;
                        end else if (cpu_mreq) begin
                            state    <= S_C_MEM;
                            mem_rd_q <= !cpu_wr;
                        end else begin
                            state <= S_C_DONE;
                        end
                    end
                end
                S_C_MEM:  state <= S_C_DONE;
                S_H_MEM:  state <= S_H_DONE;
                S_C_DONE: state <= S_IDLE;
                S_H_DONE: state <= S_IDLE;
                S_IO_WR: begin
                    if (!fifo_full) begin
                        state <= S_C_DONE;
                    end
                end
                S_IO_RD: begin
                    if (rx_valid) begin
                        rx_q  <= rx_data;
                        state <= S_C_DONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign ram_en    = (state == S_C_MEM) || (state == S_H_MEM);
    assign ram_we    = ram_en && we_q;
    assign ram_addr  = addr_q;
    assign ram_wdata = wdata_q;

    assign cpu_ready = (state == S_C_DONE);
    assign host_ack  = (state == S_H_DONE);
    assign rx_ack    = (state == S_IO_RD) && rx_valid;

    always_comb begin
        cpu_rdata = '0;
        if (cpu_ready) begin
            if (mem_rd_q) begin
                cpu_rdata = ram_rdata;
            end else if (io_rd_q) begin
                cpu_rdata = rx_q;
            end
        end
    end

    assign host_rdata = (host_ack && !we_q) ? ram_rdata : '0;

    // Fullness comes from the registered count, so a same-cycle pop never
    // makes room for this push.
    assign fifo_push = (state == S_IO_WR) && !fifo_full;
    assign tx_valid  = !fifo_empty;

    bf_out_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (BF_DATA_W)
    ) u_out_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .wdata (wdata_q),
        .full  (fifo_full),
        .pop   (tx_ready),
        .rdata (tx_data),
        .empty (fifo_empty),
        .count (fifo_count)
    );

endmodule

// File: tb/tb_bf_bus_ctrl.sv
// Directed and randomized bench for bf_bus_ctrl with a tape-array reference
// model and an expected-character queue for the tx stream.
module tb_bf_bus_ctrl;
    import bf_bus_pkg::*;

    localparam int AW    = 11;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic            clk = 1'b0;
    logic            rst;
    logic [AW-1:0]   cpu_addr;
    logic [7:0]      cpu_wdata;
    logic [7:0]      cpu_rdata;
    logic            cpu_rd, cpu_wr, cpu_mreq, cpu_ioreq, cpu_ready;
    logic [AW-1:0]   ram_addr;
    logic [7:0]      ram_wdata, ram_rdata;
    logic            ram_en, ram_we;
    logic            host_req, host_we, host_ack;
    logic [AW-1:0]   host_addr;
    logic [7:0]      host_wdata, host_rdata;
    logic [7:0]      tx_data;
    logic            tx_valid, tx_ready;
    logic [7:0]      rx_data;
    logic            rx_valid, rx_ack;
    logic [CW-1:0]   fifo_count;
    logic [2:0]      dbg_state;

    bf_bus_ctrl #(.DATA_AW(AW), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_mreq(cpu_mreq), .cpu_ioreq(cpu_ioreq),
        .cpu_ready(cpu_ready),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .ram_en(ram_en), .ram_we(ram_we),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_rdata(host_rdata), .host_ack(host_ack),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ack(rx_ack),
        .fifo_count(fifo_count), .dbg_state(dbg_state)
    );

    // Clock and reset
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];
    logic [7:0] ref_tape [0:(1<<AW)-1];
    logic [7:0] tape     [0:(1<<AW)-1];
    bit         rand_tx = 1'b0;

    int ready_cnt = 0, ack_cnt = 0, we_cnt = 0, en_cnt = 0, rx_ack_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Synchronous-read tape RAM, 1-cycle latency
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) tape[ram_addr] <= ram_wdata;
            ram_rdata <= tape[ram_addr];
        end
    end

    // Pulse counters and tx scoreboard, sampled mid-cycle
    always @(negedge clk) begin
        if (cpu_ready) ready_cnt++;
        if (host_ack)  ack_cnt++;
        if (ram_we)    we_cnt++;
        if (ram_en)    en_cnt++;
        if (rx_ack)    rx_ack_cnt++;
        if (tx_valid && tx_ready && !rst) begin
            check("tx_pop_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) check("tx_data", tx_data, exp_q.pop_front());
        end
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_tx) tx_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic cpu_access(input logic wr, input logic also_rd, input logic mreq,
                              input logic ioreq, input logic [AW-1:0] addr,
                              input logic [7:0] wd, output logic [7:0] rd, output int lat);
        cpu_addr = addr; cpu_wdata = wd; cpu_wr = wr; cpu_rd = !wr || also_rd;
        cpu_mreq = mreq; cpu_ioreq = ioreq;
        lat = 0;
        do begin tick(); lat++; end while (!cpu_ready && lat < 200);
        check("cpu_ready_seen", cpu_ready, 1);
        rd = cpu_rdata;
        cpu_rd = 0; cpu_wr = 0; cpu_mreq = 0; cpu_ioreq = 0;
        tick();
        check("cpu_ready_single", cpu_ready, 0);
    endtask

    task automatic host_access(input logic we, input logic [AW-1:0] addr,
                               input logic [7:0] wd, output logic [7:0] rd, output int lat);
        host_req = 1; host_we = we; host_addr = addr; host_wdata = wd;
        lat = 0;
        do begin tick(); lat++; end while (!host_ack && lat < 200);
        check("host_ack_seen", host_ack, 1);
        rd = host_rdata;
        host_req = 0;
        tick();
        check("host_ack_single", host_ack, 0);
    endtask

    task automatic drain();
        rand_tx = 0; tx_ready = 1;
        for (int i = 0; i < 100 && exp_q.size() > 0; i++) tick();
        check("drain_empty", exp_q.size(), 0);
        check("drain_count", fifo_count, 0);
    endtask

    initial begin
        logic [7:0] rd, hd, cd, c;
        logic [AW-1:0] a, a2;
        int lat, hc, cc, b0, b1, b2;

        for (int i = 0; i < (1 << AW); i++) begin tape[i] = 8'h00; ref_tape[i] = 8'h00; end
        rst = 1; cpu_addr = 0; cpu_wdata = 0; cpu_rd = 0; cpu_wr = 0; cpu_mreq = 0; cpu_ioreq = 0;
        host_req = 0; host_we = 0; host_addr = 0; host_wdata = 0;
        tx_ready = 0; rx_data = 0; rx_valid = 0;
        repeat (3) tick();

        check("rst_pulses", {cpu_ready, host_ack, ram_en, ram_we, rx_ack, tx_valid}, 0);
        check("rst_cpu_rdata", cpu_rdata, 0);
        check("rst_host_rdata", host_rdata, 0);
        check("rst_ram_addr", ram_addr, 0);
        check("rst_ram_wdata", ram_wdata, 0);
        check("rst_fifo_count", fifo_count, 0);
        check("rst_state", dbg_state, S_IDLE);
        rst = 0;
        tick();

        // Host preload then CPU read-back
        host_access(1, 11'd5, 8'h41, rd, lat); ref_tape[5] = 8'h41;
        check("host_wr_lat", lat, 2);
        cpu_access(0, 0, 1, 0, 11'd5, 8'h00, rd, lat);
        check("cpu_rd_lat", lat, 2);
        check("cpu_rd_data", rd, 8'h41);

        // CPU write at top address, host read-back
        b0 = we_cnt;
        cpu_access(1, 0, 1, 0, 11'h7FF, 8'h7F, rd, lat); ref_tape[11'h7FF] = 8'h7F;
        check("cpu_wr_lat", lat, 2);
        check("cpu_wr_we_pulses", we_cnt - b0, 1);
        host_access(0, 11'h7FF, 8'h00, rd, lat);
        check("host_rd_data", rd, 8'h7F);

        // Simultaneous host and CPU requests: host first, CPU three cycles later
        a = 11'd5; a2 = 11'h7FF;
        host_req = 1; host_we = 0; host_addr = a2;
        cpu_rd = 1; cpu_mreq = 1; cpu_addr = a;
        hc = -1; cc = -1; hd = 0; cd = 0;
        for (int i = 1; i <= 30 && (hc < 0 || cc < 0); i++) begin
            tick();
            if (host_ack && hc < 0) begin hc = i; hd = host_rdata; host_req = 0; end
            if (cpu_ready && cc < 0) begin cc = i; cd = cpu_rdata; cpu_rd = 0; cpu_mreq = 0; end
        end
        host_req = 0; cpu_rd = 0; cpu_mreq = 0;
        check("arb_host_cycle", hc, 2);
        check("arb_cpu_after_host", cc - hc, 3);
        check("arb_host_data", hd, ref_tape[a2]);
        check("arb_cpu_data", cd, ref_tape[a]);
        tick();

        // Randomized tape traffic against the reference array
        for (int n = 0; n < 24; n++) begin
            int kind;
            kind = $urandom_range(0, 3);
            a = AW'($urandom_range(0, (1 << AW) - 1));
            c = 8'($urandom_range(0, 255));
            case (kind)
                0: begin host_access(1, a, c, rd, lat); ref_tape[a] = c; end
                1: begin host_access(0, a, c, rd, lat); check("rnd_host_rd", rd, ref_tape[a]); end
                2: begin cpu_access(1, n[0], 1, 0, a, c, rd, lat); ref_tape[a] = c; end
                default: begin cpu_access(0, 0, 1, 0, a, c, rd, lat); check("rnd_cpu_rd", rd, ref_tape[a]); end
            endcase
            check("rnd_lat", lat, 2);
        end

        // Unqualified strobes are no-ops; both qualifiers route to I/O
        b0 = en_cnt;
        cpu_access(0, 0, 0, 0, 11'd5, 8'h00, rd, lat);
        check("noop_rd_lat", lat, 1);
        check("noop_rd_data", rd, 0);
        cpu_access(1, 0, 0, 0, 11'd5, 8'hAA, rd, lat);
        check("noop_ram_untouched", en_cnt - b0, 0);
        tx_ready = 1;
        b0 = we_cnt;
        exp_q.push_back(8'h5A);
        cpu_access(1, 0, 1, 1, 11'd6, 8'h5A, rd, lat);
        check("both_qual_lat", lat, 2);
        check("both_qual_no_ram", we_cnt - b0, 0);
        drain();
        host_access(0, 11'd5, 8'h00, rd, lat);
        check("noop_tape_kept", rd, ref_tape[5]);

        // Fill the FIFO, stall on the ninth write, then release
        tx_ready = 0;
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(8'h61 + 8'(i));
            cpu_access(1, 0, 0, 1, 11'd0, 8'h61 + 8'(i), rd, lat);
            check("fill_lat", lat, 2);
            check("fill_count", fifo_count, i + 1);
        end
        exp_q.push_back(8'h69);
        b0 = ready_cnt;
        cpu_wdata = 8'h69; cpu_wr = 1; cpu_ioreq = 1;
        repeat (10) tick();
        check("full_stall_no_ready", ready_cnt - b0, 0);
        check("full_count", fifo_count, DEPTH);
        check("full_head", tx_data, 8'h61);
        tx_ready = 1;
        lat = 0;
        do begin tick(); lat++; end while (!cpu_ready && lat < 50);
        check("unstall_lat", lat, 2);
        cpu_wr = 0; cpu_ioreq = 0;
        drain();

        // Randomized character output with a randomly stalling consumer
        rand_tx = 1;
        for (int n = 0; n < 16; n++) begin
            c = 8'($urandom_range(0, 255));
            exp_q.push_back(c);
            cpu_access(1, 0, 0, 1, 11'd0, c, rd, lat);
        end
        drain();

        // Input read waiting on rx_valid
        b0 = ready_cnt; b1 = rx_ack_cnt;
        cpu_rd = 1; cpu_ioreq = 1;
        repeat (10) tick();
        check("rx_wait_no_ready", ready_cnt - b0, 0);
        check("rx_wait_no_ack", rx_ack_cnt - b1, 0);
        rx_data = 8'h33; rx_valid = 1;
        tick();
        rx_valid = 0;
        check("rx_ready", cpu_ready, 1);
        check("rx_data", cpu_rdata, 8'h33);
        cpu_rd = 0; cpu_ioreq = 0;
        tick();
        check("rx_ack_single", rx_ack_cnt - b1, 1);
        for (int n = 0; n < 6; n++) begin
            c = 8'($urandom_range(0, 255));
            b2 = rx_ack_cnt;
            rx_data = c; rx_valid = 1;
            cpu_access(0, 0, n[0], 1, 11'd0, 8'h00, rd, lat);
            rx_valid = 0;
            check("rnd_rx_lat", lat, 2);
            check("rnd_rx_data", rd, c);
            check("rnd_rx_ack", rx_ack_cnt - b2, 1);
        end

        // Reset in the middle of a memory write with three characters queued
        tx_ready = 0;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(8'h30 + 8'(i));
            cpu_access(1, 0, 0, 1, 11'd0, 8'h30 + 8'(i), rd, lat);
        end
        check("pre_rst_count", fifo_count, 3);
        b0 = ready_cnt;
        cpu_addr = 11'd9; cpu_wdata = 8'hEE; cpu_wr = 1; cpu_mreq = 1;
        tick();
        check("pre_rst_state", dbg_state, S_C_MEM);
        #2 rst = 1;
        #1 cpu_wr = 0; cpu_mreq = 0;
        check("in_rst_tx_valid", tx_valid, 0);
        check("in_rst_count", fifo_count, 0);
        tick(); tick();
        rst = 0;
        exp_q.delete();
        tick();
        check("post_rst_state", dbg_state, S_IDLE);
        check("post_rst_no_ready", ready_cnt - b0, 0);
        check("post_rst_tx_valid", tx_valid, 0);
        check("post_rst_count", fifo_count, 0);
        host_access(0, 11'd9, 8'h00, rd, lat);
        check("post_rst_tape", rd, ref_tape[9]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
